// File: rtl/add_core_if.sv
// add_core_if: operand/result bundle for the registered adder.
//
// Parameter
//   n          operand width in bits (1..64)
// Signals
//   in_valid   operands present this cycle, capture them
//   a, b       unsigned operands, n bits
//   c_in       carry-in, weight 1
//   sum        registered result, n+1 bits, sum[n] is the carry-out
//   out_valid  sum holds a new result this cycle (no backpressure)
// Modports
//   master     producer of operands, consumer of results
//   slave      the adder itself
interface add_core_if #(
    parameter int n = 10
);
    logic         in_valid;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         c_in;
    logic [n:0]   sum;
    logic         out_valid;

    modport master (
        output in_valid, a, b, c_in,
        input  sum, out_valid
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output sum, out_valid
    );
endinterface

// File: rtl/add_core.sv
// add_core: registered n-bit unsigned adder, sum = a + b + c_in.
//
// The combinational core is a two-level carry-lookahead adder built from
// 4-bit groups. The result is captured once on the rising clock edge when
// in_valid is high and qualified with out_valid for exactly one cycle.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears sum and out_valid
//   bus     add_core_if slave: in_valid, a, b, c_in in; sum, out_valid out
module add_core #(
    parameter int n = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    add_core_if.slave  bus
);
    localparam int NG = (n + 3) / 4;    // number of 4-bit groups

    // Flattened lookahead carry over the lowest cnt (generate, propagate)
    // pairs: OR over k of g[k] & p[k+1..cnt-1], plus cin & p[0..cnt-1].
    // Written as a sum of products so no ripple chain is described.
    function automatic logic lookahead(
        input logic [63:0] gv,
        input logic [63:0] pv,
        input logic        cin,
        input int          cnt
    );
        logic res;
        logic prop;
        res  = 1'b0;
        prop = 1'b1;
        for (int k = 63; k >= 0; k--) begin
            if (k < cnt) begin
                res  = res | (prop & gv[k]);
                prop = prop & pv[k];
            end
        end
        return res | (prop & cin);
    endfunction

    logic [n-1:0]  g;
    logic [n-1:0]  p;
    logic [n:0]    c;           // c[i] = carry into bit i, c[n] = carry-out
    logic [NG-1:0] gx;          // gx[0] = c_in, gx[j+1] = group j generate
    logic [NG-1:0] px;          // px[0] = 0,    px[j+1] = group j propagate
    logic [NG-1:0] cg;          // carry into group j
    logic [n:0]    sum_next;
    logic [n:0]    sum_reg;
    logic          out_valid_reg;

    assign g = bus.a & bus.b;
    assign p = bus.a ^ bus.b;

    // c_in sits below group 0 as a pure generate term, so the second
    // level needs no separate carry-in input.
    assign gx[0] = bus.c_in;
    assign px[0] = 1'b0;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        // The top group may be partial; its missing bits act as g=0, p=0.
        localparam int BITS = ((n - 4 * gi) >= 4) ? 4 : (n - 4 * gi);

        logic [3:0] gl;
        logic [3:0] pl;

        for (genvar gk = 0; gk < 4; gk++) begin : g_bit
            if (gk < BITS) begin : g_live
                assign gl[gk] = g[4 * gi + gk];
                assign pl[gk] = p[4 * gi + gk];
            end else begin : g_pad
                assign gl[gk] = 1'b0;
                assign pl[gk] = 1'b0;
            end
        end

        // Second level: carry into this group from all lower groups.
        assign cg[gi]    = lookahead(64'(gx), 64'(px), 1'b0, gi + 1);
        assign c[4 * gi] = cg[gi];

        // First level: in-group carries. A full lower group stops at bit 3
        // because its carry-out is owned by the second level; the top
        // group also produces the final carry-out c[n].
        for (genvar gk = 1; gk <= 4; gk++) begin : g_carry
            if ((gk < BITS) || ((gk == BITS) && (gi == NG - 1))) begin : g_c
                assign c[4 * gi + gk] = lookahead(64'(gl), 64'(pl), cg[gi], gk);
            end
        end

        // Group generate/propagate feed only the groups above, so the top
        // group does not need them.
        if (gi < NG - 1) begin : g_gp
            assign gx[gi + 1] = lookahead(64'(gl), 64'(pl), 1'b0, 4);
            assign px[gi + 1] = &pl;
        end
    end

    assign sum_next = {c[n], p ^ c[n-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                sum_reg <= sum_next;
            end
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_add_core.sv
// tb_add_core: scoreboard bench for add_core.
// Main instance at n=10 runs the directed vectors, streaming, hold and
// reset cases. Four more instances (n = 1, 4, 7, 32) are swept
// exhaustively (1, 4, 7) or randomly (32) alongside random n=10 traffic.
module tb_add_core;
    logic clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int e;
    } vec_t;

    vec_t dir_vec [9];

    // Main instance, n = 10
    add_core_if #(.n(10)) bus();
    add_core #(.n(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Width-sweep instances
    function automatic int sw_width(input int i);
        return (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 7 : 32;
    endfunction

    logic [31:0] sw_a   [4];
    logic [31:0] sw_b   [4];
    logic        sw_cin [4];
    logic        sw_vld;
    logic [32:0] sw_sum [4];
    logic        sw_ov  [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int W = sw_width(gi);
        add_core_if #(.n(W)) sw_bus();
        assign sw_bus.in_valid = sw_vld;
        assign sw_bus.a        = sw_a[gi][W-1:0];
        assign sw_bus.b        = sw_b[gi][W-1:0];
        assign sw_bus.c_in     = sw_cin[gi];
        assign sw_sum[gi]      = 33'(sw_bus.sum);
        assign sw_ov[gi]       = sw_bus.out_valid;
        add_core #(.n(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sw_bus)
        );
    end

    // Scoreboard state
    logic [10:0] q [$];
    logic [32:0] sw_q [4][$];
    logic [10:0] hold_main;
    logic [32:0] sw_hold [4];
    logic        sweep_phase;
    logic        final_chk;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares on every falling clock edge, and 1 ns after reset
    // asserts to confirm the outputs clear without a clock edge.
    initial begin
        logic [10:0] e;
        logic [32:0] se;
        bit          final_seen;
        final_seen = 1'b0;
        hold_main  = '0;
        for (int i = 0; i < 4; i++) sw_hold[i] = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                chk("rst_main_sum", 64'(bus.sum), 64'd0);
                chk("rst_main_valid", 64'(bus.out_valid), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("rst_sw%0d_sum", sw_width(i)), 64'(sw_sum[i]), 64'd0);
                    chk($sformatf("rst_sw%0d_valid", sw_width(i)), 64'(sw_ov[i]), 64'd0);
                    sw_hold[i] = '0;
                end
                hold_main = '0;
            end else begin
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        chk("main_unexpected_valid", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("main_sum", 64'(bus.sum), 64'(e));
                        hold_main = e;
                        if (!sweep_phase)
                            $display("[TB] result sum=%0d expected=%0d", bus.sum, e);
                    end
                end else begin
                    chk("main_hold", 64'(bus.sum), 64'(hold_main));
                end
                for (int i = 0; i < 4; i++) begin
                    if (sw_ov[i]) begin
                        if (sw_q[i].size() == 0) begin
                            chk($sformatf("sw%0d_unexpected_valid", sw_width(i)), 64'(sw_ov[i]), 64'd0);
                        end else begin
                            se = sw_q[i].pop_front();
                            chk($sformatf("sw%0d_sum", sw_width(i)), 64'(sw_sum[i]), 64'(se));
                            sw_hold[i] = se;
                        end
                    end else begin
                        chk($sformatf("sw%0d_hold", sw_width(i)), 64'(sw_sum[i]), 64'(sw_hold[i]));
                    end
                end
                if (final_chk && !final_seen) begin
                    final_seen = 1'b1;
                    chk("main_drain", 64'(q.size()), 64'd0);
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("sw%0d_drain", sw_width(i)), 64'(sw_q[i].size()), 64'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one main-instance vector and record its expected result.
    task automatic issue(input int av, input int bv, input int cv, input int ev);
        bus.in_valid = 1'b1;
        bus.a        = 10'(av);
        bus.b        = 10'(bv);
        bus.c_in     = cv[0];
        q.push_back(11'(ev));
    endtask

    // Driver
    initial begin
        logic [63:0] t;
        int av, bv, cv, w, mask;

        dir_vec = '{
            '{0,    0,    1, 1},
            '{1,    1,    1, 3},
            '{60,   3,    1, 64},
            '{1023, 1,    0, 1024},
            '{0,    1023, 0, 1023},
            '{682,  341,  0, 1023},
            '{819,  682,  0, 1501},
            '{1023, 1023, 1, 2047},
            '{1023, 1023, 0, 2046}
        };
        sweep_phase = 1'b0;
        final_chk   = 1'b0;
        sw_vld      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_a[i]   = '0;
            sw_b[i]   = '0;
            sw_cin[i] = 1'b0;
        end

        // Reset held with live operands: outputs must stay 0.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 10'd1023;
        bus.b        = 10'd1023;
        bus.c_in     = 1'b1;
        repeat (3) step();

        // Release and capture immediately; nine back-to-back vectors.
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(dir_vec[i].a, dir_vec[i].b, dir_vec[i].c, dir_vec[i].e);
            step();
        end

        // Idle: out_valid low, sum holds 2046.
        bus.in_valid = 1'b0;
        bus.a        = 10'd5;
        repeat (3) step();

        // Stream, then reset mid-stream with a result in flight.
        issue(5, 6, 0, 11);      step();
        issue(100, 200, 1, 301); step();
        issue(512, 511, 1, 1024); step();
        #1;
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) sw_q[i].delete();
        bus.in_valid = 1'b1;
        bus.a        = 10'd77;
        bus.b        = 10'd88;
        step();
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (3) step();

        // Width sweep plus random n=10 traffic.
        sweep_phase = 1'b1;
        sw_vld      = 1'b1;
        for (int k = 0; k < 32768; k++) begin
            for (int i = 0; i < 3; i++) begin
                w         = sw_width(i);
                mask      = (1 << w) - 1;
                sw_a[i]   = 32'(k & mask);
                sw_b[i]   = 32'((k >> w) & mask);
                sw_cin[i] = ((k >> (2 * w)) & 1) != 0;
            end
            sw_a[3]   = $urandom;
            sw_b[3]   = $urandom;
            sw_cin[3] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                t = 64'(sw_a[i]) + 64'(sw_b[i]) + 64'(sw_cin[i]);
                sw_q[i].push_back(33'(t));
            end
            av = int'($urandom_range(0, 1023));
            bv = int'($urandom_range(0, 1023));
            cv = int'($urandom_range(0, 1));
            issue(av, bv, cv, av + bv + cv);
            step();
        end
        sw_vld       = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) step();

        final_chk = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
